// File: rtl/mips_pkg.sv
// Shared constants for the pipelined MIPS datapath.
package mips_pkg;

    localparam int unsigned        DATA_W           = 32;
    localparam int unsigned        WORD_BYTES       = 4;
    localparam logic [DATA_W-1:0]  NOP_INSTR        = 32'h0000_0000;
    localparam logic [DATA_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

    // Word-align a fetch target by clearing the byte-offset bits.
    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
        return {addr[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_pipeline_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid, with hold/flush/load.
// Priority is hold > flush > load. With none asserted the register holds.
import mips_pkg::*;

module ifid_pipeline_reg (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] pcplus4_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [DATA_W-1:0] pcplus4_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] instr_q,   instr_d;
    logic [DATA_W-1:0] pcplus4_q, pcplus4_d;
    logic              valid_q,   valid_d;

    // Select next contents: keep, inject a nop bubble, or capture the fetch.
    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (hold_i) begin
            instr_d   = instr_q;
        end else if (flush_i) begin
            instr_d   = NOP_INSTR;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end else if (load_i) begin
            instr_d   = instr_i;
            pcplus4_d = pcplus4_i;
            valid_d   = 1'b1;
        end
    end

    // Register with synchronous reset to an empty bubble.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: owns the PC, arbitrates stall / redirect / out-of-range /
// sequential fetch, feeds the IF/ID register and counts valid fetches.
import mips_pkg::*;

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] Readaddress,
    input  logic [31:0] instruction,
    output logic [31:0] IFID_instruction,
    output logic [31:0] IFID_PCplus4,
    output logic        IFID_valid,
    output logic [31:0] FetchCount
);

    localparam logic [DATA_W-1:0] IMEM_LIMIT = DATA_W'(IMEM_WORDS);
    localparam logic [DATA_W-1:0] COUNT_MAX  = '1;

    logic [DATA_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] redirect_tgt;
    logic              redirect;
    logic              out_of_range;
    logic              ifid_hold, ifid_flush, ifid_load;

    assign pc_plus4     = pc_q + DATA_W'(WORD_BYTES);
    assign redirect     = BranchTaken | Jump;
    assign redirect_tgt = word_align(BranchTaken ? BranchTarget : JumpTarget);
    assign out_of_range = ({2'b00, pc_q[DATA_W-1:2]} >= IMEM_LIMIT);

    // Fixed-priority next PC, counter and IF/ID control (reset is in the flop).
    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        if (Stall) begin
            // Redirect is ignored; hazard unit re-presents it after the stall.
            ifid_hold = 1'b1;
        end else if (redirect) begin
            pc_d       = redirect_tgt;
            ifid_flush = 1'b1;
        end else if (out_of_range) begin
            // Park on the bad address until a redirect pulls us back.
            ifid_flush = 1'b1;
        end else begin
            pc_d      = pc_plus4;
            ifid_load = 1'b1;
            if (count_q != COUNT_MAX) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // PC and fetch counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    ifid_pipeline_reg u_ifid (
        .clk_i     (clk),
        .reset_i   (reset),
        .hold_i    (ifid_hold),
        .flush_i   (ifid_flush),
        .load_i    (ifid_load),
        .instr_i   (instruction),
        .pcplus4_i (pc_plus4),
        .instr_o   (IFID_instruction),
        .pcplus4_o (IFID_PCplus4),
        .valid_o   (IFID_valid)
    );

    assign Readaddress = pc_q;
    assign FetchCount  = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a scoreboard of expected
// IF-stage state after each clock edge.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] Readaddress;
    logic [31:0] instruction;
    logic [31:0] IFID_instruction;
    logic [31:0] IFID_PCplus4;
    logic        IFID_valid;
    logic [31:0] FetchCount;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        v;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .Jump             (Jump),
        .JumpTarget       (JumpTarget),
        .Readaddress      (Readaddress),
        .instruction      (instruction),
        .IFID_instruction (IFID_instruction),
        .IFID_PCplus4     (IFID_PCplus4),
        .IFID_valid       (IFID_valid),
        .FetchCount       (FetchCount)
    );

    always #5 clk = ~clk;

    // Instruction memory: word i holds 32'h1000_0000 + i.
    assign instruction = 32'h1000_0000 + {2'b00, Readaddress[31:2]};

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, push the expected post-edge state, clock,
    // then pop and compare against the DUT.
    task automatic step(input string tag, input logic rst, input logic st,
                        input logic bt, input logic [31:0] btt,
                        input logic j,  input logic [31:0] jt,
                        input logic [31:0] e_pc, input logic [31:0] e_ins,
                        input logic [31:0] e_p4, input logic e_v,
                        input logic [31:0] e_cnt);
        exp_t e;
        reset        = rst;
        Stall        = st;
        BranchTaken  = bt;
        BranchTarget = btt;
        Jump         = j;
        JumpTarget   = jt;
        sb.push_back('{tag, e_pc, e_ins, e_p4, e_v, e_cnt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp(e.tag, "pc",    Readaddress,      e.pc);
        cmp(e.tag, "instr", IFID_instruction, e.ins);
        cmp(e.tag, "pcp4",  IFID_PCplus4,     e.p4);
        cmp(e.tag, "valid", {31'b0, IFID_valid}, {31'b0, e.v});
        cmp(e.tag, "count", FetchCount,       e.cnt);
    endtask

    localparam logic [31:0] W = 32'h1000_0000;

    initial begin
        reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
        BranchTarget = '0; JumpTarget = '0;
        #2;
        //   tag         rst st bt btgt      j  jtgt      pc        instr    p4        v  cnt
        step("reset",     1, 0, 0, 32'h0,    0, 32'h0,    32'h0,    32'h0,   32'h0,    0, 0);
        step("run0",      0, 0, 0, 32'h0,    0, 32'h0,    32'h4,    W+0,     32'h4,    1, 1);
        step("run1",      0, 0, 0, 32'h0,    0, 32'h0,    32'h8,    W+1,     32'h8,    1, 2);
        step("stall0",    0, 1, 0, 32'h0,    0, 32'h0,    32'h8,    W+1,     32'h8,    1, 2);
        step("stall1",    0, 1, 0, 32'h0,    0, 32'h0,    32'h8,    W+1,     32'h8,    1, 2);
        step("resume",    0, 0, 0, 32'h0,    0, 32'h0,    32'hC,    W+2,     32'hC,    1, 3);
        step("branch",    0, 0, 1, 32'h20,   0, 32'h0,    32'h20,   32'h0,   32'h0,    0, 3);
        step("tgt",       0, 0, 0, 32'h0,    0, 32'h0,    32'h24,   W+8,     32'h24,   1, 4);
        step("allhold",   0, 1, 1, 32'h40,   1, 32'h80,   32'h24,   W+8,     32'h24,   1, 4);
        step("br_wins",   0, 0, 1, 32'h41,   1, 32'h80,   32'h40,   32'h0,   32'h0,    0, 4);
        step("jmp_align", 0, 0, 0, 32'h0,    1, 32'h13,   32'h10,   32'h0,   32'h0,    0, 4);
        step("jtgt",      0, 0, 0, 32'h0,    0, 32'h0,    32'h14,   W+4,     32'h14,   1, 5);
        step("jmp_end",   0, 0, 0, 32'h0,    1, 32'hF8,   32'hF8,   32'h0,   32'h0,    0, 5);
        step("w62",       0, 0, 0, 32'h0,    0, 32'h0,    32'hFC,   W+62,    32'hFC,   1, 6);
        step("w63",       0, 0, 0, 32'h0,    0, 32'h0,    32'h100,  W+63,    32'h100,  1, 7);
        step("park0",     0, 0, 0, 32'h0,    0, 32'h0,    32'h100,  32'h0,   32'h0,    0, 7);
        step("park1",     0, 0, 0, 32'h0,    0, 32'h0,    32'h100,  32'h0,   32'h0,    0, 7);
        step("unpark",    0, 0, 0, 32'h0,    1, 32'h0,    32'h0,    32'h0,   32'h0,    0, 7);
        step("w0",        0, 0, 0, 32'h0,    0, 32'h0,    32'h4,    W+0,     32'h4,    1, 8);
        step("to24",      0, 0, 0, 32'h0,    1, 32'h18,   32'h18,   32'h0,   32'h0,    0, 8);
        step("stall24",   0, 1, 0, 32'h0,    0, 32'h0,    32'h18,   32'h0,   32'h0,    0, 8);
        step("rst_stall", 1, 1, 1, 32'h80,   1, 32'h80,   32'h0,    32'h0,   32'h0,    0, 0);
        step("post_rst",  0, 0, 0, 32'h0,    0, 32'h0,    32'h4,    W+0,     32'h4,    1, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
